// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard controller: shadow EX/MEM/WB scoreboard, latch enables/flushes, RUN/DWAIT/HALTED.
// Optional macro HAZARD_FORWARD_EN: load-use-only stalls plus EX operand forwarding selects.
module hazard_scoreboard_unit #(
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [AW-1:0]    id_dest,
  input  logic             id_wen,
  input  logic             id_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dhit,
  input  logic             ihit,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             halted
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] dest;
    logic          wen;
    logic          load;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
  } entry_t;

  typedef enum logic [1:0] {StRun, StDwait, StHalted} state_t;

  entry_t           r_ex, r_mem, r_wb;
  entry_t           w_ex_d, w_mem_d, w_wb_d;
  state_t           r_state;
  logic [CNT_W-1:0] r_stall, r_flush;
  logic             w_hazard, w_freeze, w_unused;

  function automatic logic hit(input entry_t e, input logic [AW-1:0] r);
    return e.valid && e.wen && (e.dest != '0) && (e.dest == r);
  endfunction

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be forwarded in time; one bubble puts it in WB.
  assign w_hazard = r_ex.load && ((id_uses_rs && hit(r_ex, id_rs)) ||
                                  (id_uses_rt && hit(r_ex, id_rt)));

  function automatic logic [1:0] fwd_sel(input entry_t m, input entry_t w,
                                         input logic [AW-1:0] r);
    if (hit(m, r) && !m.load) return 2'b01;
    if (hit(w, r)) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (nRST && r_ex.valid) begin
      fwd_a = fwd_sel(r_mem, r_wb, r_ex.rs);
      fwd_b = fwd_sel(r_mem, r_wb, r_ex.rt);
    end
  end
`else
  // WB writes first in the register file, so only EX and MEM producers block decode.
  assign w_hazard = (id_uses_rs && (hit(r_ex, id_rs) || hit(r_mem, id_rs))) ||
                    (id_uses_rt && (hit(r_ex, id_rt) || hit(r_mem, id_rt)));
  assign fwd_a    = 2'b00;
  assign fwd_b    = 2'b00;
`endif

  assign w_unused  = ^{r_ex, r_mem, r_wb};
  assign w_freeze  = ((r_state == StDwait) || mem_req) && !dhit;
  assign halted    = nRST && (r_state == StHalted);
  assign stall_cnt = r_stall;
  assign flush_cnt = r_flush;

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (!nRST || (r_state == StHalted)) begin
      pc_en = 1'b0;
    end else if (w_freeze) begin
      memwb_en    = 1'b1;
      memwb_flush = 1'b1;
    end else if (ex_redirect) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_hazard) begin
      {idex_en, exmem_en, memwb_en} = 3'b111;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
      ifid_flush = 1'b1;
    end else begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
    end
  end

  // Shadow entries follow the same enables/flushes the real latches see.
  always_comb begin
    w_ex_d  = r_ex;
    w_mem_d = r_mem;
    w_wb_d  = r_wb;
    if (idex_flush)    w_ex_d = '0;
    else if (idex_en)  w_ex_d = '{valid: 1'b1, dest: id_dest, wen: id_wen, load: id_load,
                                  rs: id_rs, rt: id_rt};
    if (exmem_flush)   w_mem_d = '0;
    else if (exmem_en) w_mem_d = r_ex;
    if (memwb_flush)   w_wb_d = '0;
    else if (memwb_en) w_wb_d = r_mem;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_state <= StRun;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_ex  <= w_ex_d;
      r_mem <= w_mem_d;
      r_wb  <= w_wb_d;
      case (r_state)
        StHalted: r_state <= StHalted;
        default: begin
          if (wb_halt)       r_state <= StHalted;
          else if (w_freeze) r_state <= StDwait;
          else               r_state <= StRun;
        end
      endcase
      if (!pc_en && (r_state != StHalted) && (r_stall != '1)) r_stall <= r_stall + 1'b1;
      if ((ifid_flush || idex_flush) && (r_flush != '1))      r_flush <= r_flush + 1'b1;
    end
  end

endmodule
